avm_cmd_master: RTL and testbench

- Avalon-MM initiator that drives the s1 port of the on-chip PIO and other simple Qsys slaves from fabric logic. The counter FSM uses it to write and read registers without a Nios core.
- Provides a one-outstanding-command interface on the user side and an Avalon-MM master port on the bus side.
- Supports waitrequest, fixed read latency and a waitrequest timeout.

---
 rtl/avm_cmd_master_if.sv | 35 +++
 rtl/avm_cmd_master.sv | 159 +++++++++++++++
 tb/tb_avm_cmd_master.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/avm_cmd_master_if.sv
// Command/response handshake plus Avalon-MM initiator signals for avm_cmd_master.
// master = the avm_cmd_master side, slave = the user logic / bus fabric side.
interface avm_cmd_master_if #(
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );
endinterface

// File: rtl/avm_cmd_master.sv
// One-outstanding-command Avalon-MM initiator with waitrequest, fixed read latency and timeout.
// Define AVM_CMD_MASTER_VERIFY_EN to add write-then-readback verification (VFY state, VERIFY_MASK).
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// BUS   | chipselect and one strobe asserted until waitrequest drops or the timeout expires
// LAT   | read accepted, counting READ_LATENCY cycles before sampling readdata
// RESP  | rsp_valid pulse for one cycle
// VFY   | (verify build) one idle bus cycle, then readback of the written address
module avm_cmd_master #(
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
`ifdef AVM_CMD_MASTER_VERIFY_EN
  , parameter logic [31:0] VERIFY_MASK = 32'h0000_000F
`endif
) (
  input  logic             clk,
  input  logic             reset,
  avm_cmd_master_if.master bus
);

`ifdef AVM_CMD_MASTER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, BUS, LAT, RESP, VFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUS, LAT, RESP} state_t;
`endif

  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT > 1) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [2:0]      LAT_LOAD = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  state_t          state;
  logic            is_write;
  logic [TO_W-1:0] wait_cnt;
  logic [2:0]      lat_cnt;
  logic            verify_bad;

`ifdef AVM_CMD_MASTER_VERIFY_EN
  logic verifying;

  // avm_writedata still holds the written value during the readback
  assign verify_bad = verifying &&
                      ((bus.avm_readdata & VERIFY_MASK) != (bus.avm_writedata & VERIFY_MASK));
`else
  assign verify_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      is_write           <= 1'b0;
      wait_cnt           <= '0;
      lat_cnt            <= '0;
      bus.cmd_ready      <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_error      <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_read_n     <= 1'b1;
      bus.avm_writedata  <= '0;
`ifdef AVM_CMD_MASTER_VERIFY_EN
      verifying          <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready      <= 1'b0;
            is_write           <= bus.cmd_write;
            bus.avm_address    <= bus.cmd_address;
            bus.avm_writedata  <= bus.cmd_wdata;
            bus.avm_chipselect <= 1'b1;
            bus.avm_write_n    <= ~bus.cmd_write;
            bus.avm_read_n     <= bus.cmd_write;
            wait_cnt           <= TO_LOAD;
`ifdef AVM_CMD_MASTER_VERIFY_EN
            verifying          <= 1'b0;
`endif
            state              <= BUS;
          end
        end

        BUS: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_read_n     <= 1'b1;
            if (is_write) begin
`ifdef AVM_CMD_MASTER_VERIFY_EN
              state         <= VFY;
`else
              bus.rsp_error <= 1'b0;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
`endif
            end else if (READ_LATENCY == 0) begin
              bus.rsp_rdata <= bus.avm_readdata;
              bus.rsp_error <= verify_bad;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= LAT;
            end
          end else if (TO_EN && wait_cnt == '0) begin
            // abandon the transfer: strobes drop, error response with zero data
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_read_n     <= 1'b1;
            bus.rsp_rdata      <= '0;
            bus.rsp_error      <= 1'b1;
            bus.rsp_valid      <= 1'b1;
            state              <= RESP;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        LAT: begin
          if (lat_cnt == 3'd0) begin
            bus.rsp_rdata <= bus.avm_readdata;
            bus.rsp_error <= verify_bad;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        RESP: begin
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end

`ifdef AVM_CMD_MASTER_VERIFY_EN
        VFY: begin
          is_write           <= 1'b0;
          verifying          <= 1'b1;
          bus.avm_chipselect <= 1'b1;
          bus.avm_read_n     <= 1'b0;
          wait_cnt           <= TO_LOAD;
          state              <= BUS;
        end
`endif

        default: begin
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avm_cmd_master.sv
// Directed bench: dut0 (READ_LATENCY=0, TIMEOUT=8) on a 4-bit PIO model, dut2 (READ_LATENCY=2).
module tb_avm_cmd_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  avm_cmd_master_if #(.ADDR_W(2)) bus0 ();
  avm_cmd_master_if #(.ADDR_W(2)) bus2 ();

  avm_cmd_master #(.ADDR_W(2), .READ_LATENCY(0), .TIMEOUT(8)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0));
  avm_cmd_master #(.ADDR_W(2), .READ_LATENCY(2), .TIMEOUT(8)) dut2 (
    .clk(clk), .reset(rst), .bus(bus2));

  // PIO model: addr 0 = 4-bit data register, other addresses read as zero
  logic [3:0]  pio_out = 4'h0;
  logic        wait0 = 1'b0;
  logic        wait2 = 1'b0;
  logic [31:0] rdata2 = 32'hDEAD_BEEF;
  int          wr_cnt0 = 0;
  int          rd_cnt0 = 0;

  assign bus0.avm_readdata    = (bus0.avm_address == 2'd0) ? {28'd0, pio_out} : 32'd0;
  assign bus0.avm_waitrequest = wait0;
  assign bus2.avm_readdata    = rdata2;
  assign bus2.avm_waitrequest = wait2;

  always @(posedge clk) begin
    if (bus0.avm_chipselect && !bus0.avm_write_n && !wait0 && bus0.avm_address == 2'd0)
      pio_out <= bus0.avm_writedata[3:0];
    if (bus0.avm_chipselect && !bus0.avm_write_n) wr_cnt0 <= wr_cnt0 + 1;
    if (bus0.avm_chipselect && !bus0.avm_read_n)  rd_cnt0 <= rd_cnt0 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run0(input logic wr, input logic [1:0] a, input logic [31:0] d, output int lat);
    bus0.cmd_valid   = 1'b1;
    bus0.cmd_write   = wr;
    bus0.cmd_address = a;
    bus0.cmd_wdata   = d;
    tick();
    lat = 1;
    bus0.cmd_valid = 1'b0;
    while (bus0.rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  ok;
    bit  seen;

    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_address = '0; bus0.cmd_wdata = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_address = '0; bus2.cmd_wdata = '0;

    // reset values
    tick(); tick();
    check("rst_cmd_ready", bus0.cmd_ready, 1);
    check("rst_rsp_valid", bus0.rsp_valid, 0);
    check("rst_rsp_rdata", bus0.rsp_rdata, 0);
    check("rst_rsp_error", bus0.rsp_error, 0);
    check("rst_chipselect", bus0.avm_chipselect, 0);
    check("rst_write_n", bus0.avm_write_n, 1);
    check("rst_read_n", bus0.avm_read_n, 1);
    check("rst_address", bus0.avm_address, 0);
    check("rst_writedata", bus0.avm_writedata, 0);
    check("rst_cmd_ready2", bus2.cmd_ready, 1);
    rst = 1'b0;
    tick();

    // write 0xA to PIO, zero wait
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1; bus0.cmd_address = 2'd0; bus0.cmd_wdata = 32'h0000_000A;
    check("wr_ready", bus0.cmd_ready, 1);
    tick();
    bus0.cmd_valid = 1'b0;
    check("wr_bus_cs", bus0.avm_chipselect, 1);
    check("wr_bus_write_n", bus0.avm_write_n, 0);
    check("wr_bus_read_n", bus0.avm_read_n, 1);
    check("wr_bus_wdata", bus0.avm_writedata, 32'h0000_000A);
    check("wr_bus_ready", bus0.cmd_ready, 0);
    tick();
    check("wr_rsp_valid", bus0.rsp_valid, 1);
    check("wr_rsp_error", bus0.rsp_error, 0);
    check("wr_strobe_drop", bus0.avm_write_n, 1);
    check("wr_cs_drop", bus0.avm_chipselect, 0);
    check("wr_pio_out", pio_out, 4'hA);
    tick();
    check("wr_rsp_clear", bus0.rsp_valid, 0);
    check("wr_idle_ready", bus0.cmd_ready, 1);
    check("wr_strobe_cycles", wr_cnt0, 1);

    // read addr 1 with cmd_valid held through RESP, then read addr 0
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b0; bus0.cmd_address = 2'd1; bus0.cmd_wdata = 32'hFFFF_FFFF;
    tick();
    check("rd1_read_n", bus0.avm_read_n, 0);
    check("rd1_write_n", bus0.avm_write_n, 1);
    check("rd1_address", bus0.avm_address, 1);
    bus0.cmd_address = 2'd0;
    tick();
    check("rd1_rsp_valid", bus0.rsp_valid, 1);
    check("rd1_rdata", bus0.rsp_rdata, 0);
    check("rd1_read_n_drop", bus0.avm_read_n, 1);
    check("rd1_ignored_addr", bus0.avm_address, 1);
    check("rd1_resp_ready", bus0.cmd_ready, 0);
    tick();
    check("rd_b2b_idle_ready", bus0.cmd_ready, 1);
    check("rd_b2b_idle_cs", bus0.avm_chipselect, 0);
    tick();
    bus0.cmd_valid = 1'b0;
    check("rd0_read_n", bus0.avm_read_n, 0);
    check("rd0_address", bus0.avm_address, 0);
    tick();
    check("rd0_rsp_valid", bus0.rsp_valid, 1);
    check("rd0_rdata", bus0.rsp_rdata, 32'h0000_000A);
    check("rd0_error", bus0.rsp_error, 0);
    tick();
    check("rd_strobe_cycles", rd_cnt0, 2);

    // write 0x3 with five waitrequest cycles
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1; bus0.cmd_address = 2'd0; bus0.cmd_wdata = 32'h3;
    wait0 = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) bus0.cmd_valid = 1'b0;
      if (k == 6) wait0 = 1'b0;
      if (!(bus0.avm_chipselect && !bus0.avm_write_n && bus0.avm_read_n &&
            bus0.avm_writedata == 32'h3 && bus0.avm_address == 2'd0)) ok = 1'b0;
      if (bus0.rsp_valid) ok = 1'b0;
    end
    check("ws_stable_6", ok, 1);
    tick();
    check("ws_rsp_valid_at_7", bus0.rsp_valid, 1);
    check("ws_rsp_error", bus0.rsp_error, 0);
    check("ws_rdata_unchanged", bus0.rsp_rdata, 32'h0000_000A);
    check("ws_pio_out", pio_out, 4'h3);
    check("ws_cs_drop", bus0.avm_chipselect, 0);
    tick();

    // timeout: waitrequest stuck high
    bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1; bus0.cmd_address = 2'd0; bus0.cmd_wdata = 32'h7;
    wait0 = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) bus0.cmd_valid = 1'b0;
      if (!(bus0.avm_chipselect && !bus0.avm_write_n)) ok = 1'b0;
      if (bus0.rsp_valid) ok = 1'b0;
    end
    check("to_strobes_8", ok, 1);
    tick();
    check("to_cs_drop", bus0.avm_chipselect, 0);
    check("to_write_n_drop", bus0.avm_write_n, 1);
    check("to_rsp_valid", bus0.rsp_valid, 1);
    check("to_rsp_error", bus0.rsp_error, 1);
    check("to_rsp_rdata", bus0.rsp_rdata, 0);
    check("to_pio_unchanged", pio_out, 4'h3);
    wait0 = 1'b0;
    tick();
    check("to_idle_ready", bus0.cmd_ready, 1);
    run0(1'b0, 2'd0, 32'h0, lat);
    check("after_to_latency", lat, 2);
    check("after_to_rdata", bus0.rsp_rdata, 32'h3);
    check("after_to_error", bus0.rsp_error, 0);
    tick();

    // dut2: READ_LATENCY=2, data valid only two cycles after bus acceptance
    bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b0; bus2.cmd_address = 2'd1;
    tick();
    bus2.cmd_valid = 1'b0;
    check("rl2_read_n", bus2.avm_read_n, 0);
    check("rl2_cs", bus2.avm_chipselect, 1);
    tick();
    check("rl2_lat1_read_n", bus2.avm_read_n, 1);
    check("rl2_lat1_rsp", bus2.rsp_valid, 0);
    tick();
    rdata2 = 32'h1234_5678;
    check("rl2_lat2_rsp", bus2.rsp_valid, 0);
    tick();
    rdata2 = 32'hDEAD_BEEF;
    check("rl2_rsp_valid_at_4", bus2.rsp_valid, 1);
    check("rl2_rdata", bus2.rsp_rdata, 32'h1234_5678);
    check("rl2_error", bus2.rsp_error, 0);
    tick();
    check("rl2_rsp_clear", bus2.rsp_valid, 0);

    // reset asserted while dut2 is stalled in BUS
    bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b1; bus2.cmd_address = 2'd2; bus2.cmd_wdata = 32'h55;
    wait2 = 1'b1;
    tick();
    bus2.cmd_valid = 1'b0;
    check("rst_mid_pre_write_n", bus2.avm_write_n, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_write_n", bus2.avm_write_n, 1);
    check("rst_mid_cs", bus2.avm_chipselect, 0);
    check("rst_mid_ready", bus2.cmd_ready, 1);
    tick();
    rst = 1'b0;
    wait2 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus2.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("rst_mid_no_rsp", seen, 0);
    check("rst_mid_idle_cs", bus2.avm_chipselect, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
